// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - two-requester round-robin arbiter for the SDRAM core request port
//
// Purpose: shares one sdram_axi_core request port between two requesters. A grant is
// held for a whole burst, and every accepted beat records its owner in an in-order FIFO.
// Core acks are routed back to the owner at the FIFO head.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mN_wr_i/rd_i/len_i/addr_i/write_data_i   requester N request (N = 0, 1)
//   mN_accept_o                  requester N beat accepted this cycle
//   mN_ack_o/error_o/read_data_o requester N response; error and data are valid with ack
//   ram_wr_o/rd_o/len_o/addr_o/write_data_o  request to the core
//   ram_accept_i/ack_i/error_i/read_data_i   response from the core
//   proto_err_o                  sticky: ack seen with nothing outstanding
module sdram_port_arb #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_rd_i,
    input  logic [7:0]  m0_len_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_write_data_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_read_data_o,
    input  logic [3:0]  m1_wr_i,
    input  logic        m1_rd_i,
    input  logic [7:0]  m1_len_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_write_data_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_read_data_o,
    output logic [3:0]  ram_wr_o,
    output logic        ram_rd_o,
    output logic [7:0]  ram_len_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    input  logic        ram_accept_i,
    input  logic        ram_ack_i,
    input  logic        ram_error_i,
    input  logic [31:0] ram_read_data_i,
    output logic        proto_err_o
);

    localparam int AW = $clog2(OUTSTANDING);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [7:0]       remaining;
    logic [OUTSTANDING-1:0] fifo_id;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             proto_err;

    logic req0, req1;
    logic sel, sel_valid;
    logic fifo_full, fifo_empty;
    logic beat_accept;
    logic ack_hit;
    logic head_id;
    logic [7:0] sel_len;

    assign req0       = m0_rd_i | (|m0_wr_i);
    assign req1       = m1_rd_i | (|m1_wr_i);
    assign fifo_full  = (count == CW'(OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head_id    = fifo_id[rd_ptr];

    // Grant selection: a locked burst keeps its owner; otherwise the requester
    // that did not win last time has priority when both are asking.
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        if (state == LOCK) begin
            sel       = owner;
            sel_valid = owner ? req1 : req0;
        end else if (req0 && req1) begin
            sel       = ~last_grant;
            sel_valid = 1'b1;
        end else if (req0) begin
            sel       = 1'b0;
            sel_valid = 1'b1;
        end else if (req1) begin
            sel       = 1'b1;
            sel_valid = 1'b1;
        end
        if (rst_i) begin
            sel_valid = 1'b0;
        end
    end

    assign beat_accept = ram_accept_i & sel_valid & ~fifo_full;
    assign m0_accept_o = beat_accept & ~sel;
    assign m1_accept_o = beat_accept & sel;
    assign sel_len     = sel ? m1_len_i : m0_len_i;

    // Request mux; the strobes are withheld while the FIFO is full so the core
    // never accepts a beat whose ack could not be tracked.
    always_comb begin
        ram_wr_o         = 4'd0;
        ram_rd_o         = 1'b0;
        ram_len_o        = 8'd0;
        ram_addr_o       = 32'd0;
        ram_write_data_o = 32'd0;
        if (sel_valid) begin
            ram_len_o        = sel_len;
            ram_addr_o       = sel ? m1_addr_i : m0_addr_i;
            ram_write_data_o = sel ? m1_write_data_i : m0_write_data_i;
            if (!fifo_full) begin
                ram_wr_o = sel ? m1_wr_i : m0_wr_i;
                ram_rd_o = sel ? m1_rd_i : m0_rd_i;
            end
        end
    end

    assign ack_hit        = ram_ack_i & ~fifo_empty & ~rst_i;
    assign m0_ack_o       = ack_hit & ~head_id;
    assign m1_ack_o       = ack_hit & head_id;
    assign m0_error_o     = ram_error_i & ~rst_i;
    assign m1_error_o     = ram_error_i & ~rst_i;
    assign m0_read_data_o = rst_i ? 32'd0 : ram_read_data_i;
    assign m1_read_data_o = rst_i ? 32'd0 : ram_read_data_i;
    assign proto_err_o    = proto_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            remaining  <= 8'd0;
            fifo_id    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (beat_accept) begin
                fifo_id[wr_ptr] <= sel;
                wr_ptr          <= wr_ptr + 1'b1;
                if (state == IDLE) begin
                    last_grant <= sel;
                    owner      <= sel;
                    if (sel_len != 8'd0) begin
                        state     <= LOCK;
                        remaining <= sel_len;
                    end
                end else begin
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state <= IDLE;
                    end
                end
            end
            if (ack_hit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ram_ack_i && fifo_empty) begin
                proto_err <= 1'b1;
            end
            case ({beat_accept, ack_hit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb/tb_sdram_port_arb.sv - randomized scoreboard bench for sdram_port_arb
module tb_sdram_port_arb;

    localparam int OUT  = 4;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  m0_wr, m1_wr;
    logic        m0_rd, m1_rd;
    logic [7:0]  m0_len, m1_len;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_accept, m1_accept, m0_ack, m1_ack, m0_error, m1_error;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  ram_wr;
    logic        ram_rd;
    logic [7:0]  ram_len;
    logic [31:0] ram_addr, ram_wdata;
    logic        ram_accept, ram_ack, ram_error;
    logic [31:0] ram_rdata;
    logic        proto_err;

    always #5 clk = ~clk;

    sdram_port_arb #(.OUTSTANDING(OUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_wr_i(m0_wr), .m0_rd_i(m0_rd), .m0_len_i(m0_len), .m0_addr_i(m0_addr),
        .m0_write_data_i(m0_wdata), .m0_accept_o(m0_accept), .m0_ack_o(m0_ack),
        .m0_error_o(m0_error), .m0_read_data_o(m0_rdata),
        .m1_wr_i(m1_wr), .m1_rd_i(m1_rd), .m1_len_i(m1_len), .m1_addr_i(m1_addr),
        .m1_write_data_i(m1_wdata), .m1_accept_o(m1_accept), .m1_ack_o(m1_ack),
        .m1_error_o(m1_error), .m1_read_data_o(m1_rdata),
        .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_len_o(ram_len), .ram_addr_o(ram_addr),
        .ram_write_data_o(ram_wdata), .ram_accept_i(ram_accept), .ram_ack_i(ram_ack),
        .ram_error_i(ram_error), .ram_read_data_i(ram_rdata), .proto_err_o(proto_err)
    );

    typedef struct {
        bit          in_rst;
        bit          acc0;
        bit          acc1;
        bit          rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        bit          perr;
        bit          ack_drv;
    } cyc_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          err;
    } ack_t;

    cyc_t exp_cyc[$];
    ack_t exp_ack[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester stimulus state
    bit          act[2];
    bit          iswr[2];
    int          blen[2];
    int          beat[2];
    int          hold[2];
    logic [31:0] base[2];
    logic [31:0] wdat[2];
    logic [3:0]  strb[2];

    // Reference model: who won last, whether a burst is in progress, and the
    // in-order list of owners still waiting for an ack.
    int last_grant;
    int owner;
    int rem;
    bit lock;
    int oq[$];
    bit perr_m;

    initial begin
        bit   req[2];
        bit   rd_n[2];
        logic [3:0]  wr_n[2];
        logic [31:0] addr_n[2];
        int   holdoff;
        int   stale;
        int   sel;
        bit   selv;
        bit   full;
        bit   acc;
        cyc_t c;
        ack_t a;

        m0_wr = 0; m1_wr = 0; m0_rd = 0; m1_rd = 0; m0_len = 0; m1_len = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        ram_accept = 0; ram_ack = 0; ram_error = 0; ram_rdata = 0;
        for (int n = 0; n < 2; n++) begin
            act[n] = 0; hold[n] = 0; beat[n] = 0; blen[n] = 0; iswr[n] = 0;
            base[n] = 0; wdat[n] = 0; strb[n] = 0;
        end
        last_grant = 1; owner = 0; rem = 0; lock = 0; perr_m = 0;
        holdoff = 0; stale = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc < 3) || (cyc >= 1200 && cyc < 1203) || (cyc >= 2200 && cyc < 2202);
            if (cyc == 100 || cyc == 1185 || cyc == 2500) holdoff = 25;
            if (cyc == 1203) stale = 2;

            for (int n = 0; n < 2; n++) begin
                if (rst) begin
                    act[n] = 0;
                    hold[n] = $urandom_range(0, 2);
                end else begin
                    if (hold[n] > 0) hold[n]--;
                    if (!act[n] && hold[n] == 0) begin
                        act[n]  = 1;
                        iswr[n] = $urandom_range(0, 1);
                        blen[n] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
                        beat[n] = 0;
                        base[n] = $urandom & 32'hFFFF_FFFC;
                        wdat[n] = $urandom;
                        strb[n] = 4'($urandom_range(1, 15));
                    end
                end
                req[n]    = act[n] && hold[n] == 0;
                rd_n[n]   = req[n] && !iswr[n];
                wr_n[n]   = (req[n] && iswr[n]) ? strb[n] : 4'd0;
                addr_n[n] = base[n] + 32'(beat[n] * 4);
            end

            m0_rd = rd_n[0]; m0_wr = wr_n[0]; m0_len = 8'(blen[0]); m0_addr = addr_n[0];
            m0_wdata = wdat[0] ^ 32'(beat[0]);
            m1_rd = rd_n[1]; m1_wr = wr_n[1]; m1_len = 8'(blen[1]); m1_addr = addr_n[1];
            m1_wdata = wdat[1] ^ 32'(beat[1]);

            ram_accept = ($urandom_range(0, 3) != 0);
            ram_rdata  = $urandom;
            ram_error  = ($urandom_range(0, 7) == 0);
            if (rst) begin
                ram_ack = 0;
            end else if (stale > 0) begin
                ram_ack = 1;
                stale--;
            end else if (holdoff > 0) begin
                ram_ack = 0;
                holdoff--;
            end else begin
                ram_ack = (oq.size() > 0) && ($urandom_range(0, 2) != 0);
            end

            if (rst) begin
                c = '{in_rst: 1, acc0: 0, acc1: 0, rd: 0, wr: 4'd0, addr: 32'd0, perr: 0, ack_drv: 0};
                exp_cyc.push_back(c);
                last_grant = 1; owner = 0; rem = 0; lock = 0; perr_m = 0;
                oq.delete();
            end else begin
                full = (oq.size() >= OUT);
                if (lock) begin
                    sel  = owner;
                    selv = req[owner];
                end else if (req[0] && req[1]) begin
                    sel  = 1 - last_grant;
                    selv = 1;
                end else begin
                    sel  = req[1] ? 1 : 0;
                    selv = req[0] || req[1];
                end
                acc = ram_accept && selv && !full;

                c.in_rst  = 0;
                c.acc0    = acc && sel == 0;
                c.acc1    = acc && sel == 1;
                c.rd      = (selv && !full) ? rd_n[sel] : 1'b0;
                c.wr      = (selv && !full) ? wr_n[sel] : 4'd0;
                c.addr    = selv ? addr_n[sel] : 32'd0;
                c.perr    = perr_m;
                c.ack_drv = ram_ack;
                exp_cyc.push_back(c);

                if (ram_ack) begin
                    a.data = ram_rdata;
                    a.err  = ram_error;
                    if (oq.size() == 0) begin
                        a.id   = -1;
                        perr_m = 1;
                    end else begin
                        a.id = oq.pop_front();
                    end
                    exp_ack.push_back(a);
                end

                if (acc) begin
                    oq.push_back(sel);
                    if (!lock) begin
                        last_grant = sel;
                        owner      = sel;
                        if (blen[sel] > 0) begin
                            lock = 1;
                            rem  = blen[sel];
                        end
                    end else begin
                        rem--;
                        if (rem == 0) lock = 0;
                    end
                    beat[sel]++;
                    if (beat[sel] > blen[sel]) begin
                        act[sel]  = 0;
                        hold[sel] = $urandom_range(0, 4);
                    end else if ($urandom_range(0, 3) == 0) begin
                        hold[sel] = $urandom_range(1, 3);
                    end
                end
            end
        end

        @(negedge clk);
        #1;
        chk("leftover_expectations", 64'(exp_cyc.size() + exp_ack.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: checks the DUT against the expectations queued for this cycle.
    initial begin
        cyc_t e;
        ack_t a;
        forever begin
            @(negedge clk);
            if (exp_cyc.size() != 0) begin
                e = exp_cyc.pop_front();
                chk("m0_accept", 64'(m0_accept), 64'(e.acc0));
                chk("m1_accept", 64'(m1_accept), 64'(e.acc1));
                chk("ram_rd", 64'(ram_rd), 64'(e.rd));
                chk("ram_wr", 64'(ram_wr), 64'(e.wr));
                chk("ram_addr", 64'(ram_addr), 64'(e.addr));
                chk("proto_err", 64'(proto_err), 64'(e.perr));
                if (e.in_rst) begin
                    chk("rst_outputs", {30'd0, m0_ack, m1_ack, m0_error, m1_error, m0_rdata | m1_rdata},
                        64'd0);
                end else if (e.ack_drv || m0_ack || m1_ack) begin
                    if (exp_ack.size() == 0) begin
                        chk("unexpected_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
                    end else begin
                        a = exp_ack.pop_front();
                        if (a.id < 0) begin
                            chk("stray_ack_routed", {62'd0, m1_ack, m0_ack}, 64'd0);
                        end else begin
                            chk("ack_route", {62'd0, m1_ack, m0_ack}, (a.id == 1) ? 64'd2 : 64'd1);
                            chk("ack_data", 64'(a.id == 1 ? m1_rdata : m0_rdata), 64'(a.data));
                            chk("ack_error", 64'(a.id == 1 ? m1_error : m0_error), 64'(a.err));
                        end
                    end
                end else begin
                    chk("idle_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
                end
            end
        end
    end

endmodule
